// File: rtl/ldm_sequencer_if.sv
// ldm_sequencer_if: decode-side bundle between the decode stage and the
// block-transfer micro-op sequencer.
//   master: decode / execute side. Drives instruction fields, flush and
//           uop_ready, and observes the micro-op stream and status.
//   slave : the sequencer itself.
//   start, reglist, base, up, pre, wb, load : block-transfer instruction
//   flush, uop_ready                        : pipeline control
//   busy, stallF, done                      : sequencer status
//   uop_*                                   : presented micro-op
interface ldm_sequencer_if #(
  parameter int NREGS  = 16,
  parameter int ADDR_W = 32
);
  localparam int RIDX_W = $clog2(NREGS);

  logic              start;
  logic [NREGS-1:0]  reglist;
  logic [ADDR_W-1:0] base;
  logic              up;
  logic              pre;
  logic              wb;
  logic              load;
  logic              flush;
  logic              uop_ready;
  logic              busy;
  logic              stallF;
  logic              uop_valid;
  logic [RIDX_W-1:0] uop_reg;
  logic [ADDR_W-1:0] uop_addr;
  logic              uop_load;
  logic              uop_wb;
  logic              uop_last;
  logic              done;

  modport master (
    output start, reglist, base, up, pre, wb, load, flush, uop_ready,
    input  busy, stallF, uop_valid, uop_reg, uop_addr, uop_load, uop_wb,
           uop_last, done
  );

  modport slave (
    input  start, reglist, base, up, pre, wb, load, flush, uop_ready,
    output busy, stallF, uop_valid, uop_reg, uop_addr, uop_load, uop_wb,
           uop_last, done
  );
endinterface

// File: rtl/ldm_sequencer.sv
// ldm_sequencer: walks the register list of an LDM/STM-style block transfer,
// emitting one memory micro-op per selected register (lowest register first,
// ascending addresses) and an optional base-writeback micro-op, while holding
// fetch/decode stalled.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset
//   bus  : ldm_sequencer_if slave modport (instruction in, micro-ops out)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no sequence; capture a new instruction on start & ~flush
//   S_XFER  | presenting memory micro-ops, one per remaining mask bit
//   S_WBACK | presenting the single base-writeback micro-op
module ldm_sequencer #(
  parameter int NREGS  = 16,
  parameter int ADDR_W = 32,
  parameter int WORD_B = 4
) (
  input logic           clk,
  input logic           rst,
  ldm_sequencer_if.slave bus
);
  localparam int RIDX_W = $clog2(NREGS);
  localparam int CNT_W  = $clog2(NREGS + 1);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WBACK} state_t;

  state_t            state_q, state_d;
  logic [NREGS-1:0]  mask_q, mask_d;
  logic              wb_q, wb_d;
  logic [ADDR_W-1:0] wbval_q, wbval_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              uop_valid_q, uop_valid_d;
  logic [RIDX_W-1:0] uop_reg_q, uop_reg_d;
  logic [ADDR_W-1:0] uop_addr_q, uop_addr_d;
  logic              uop_load_q, uop_load_d;
  logic              uop_wb_q, uop_wb_d;
  logic              uop_last_q, uop_last_d;

  function automatic logic [CNT_W-1:0] popcnt(input logic [NREGS-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c = c + CNT_W'(m[i]);
    return c;
  endfunction

  function automatic logic [RIDX_W-1:0] lowest(input logic [NREGS-1:0] m);
    logic [RIDX_W-1:0] idx;
    idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) if (m[i]) idx = RIDX_W'(i);
    return idx;
  endfunction

  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] stride, span, start_addr, wbval_new;
  logic [NREGS-1:0]  mask_rest;
  logic              to_idle;

  assign stride    = ADDR_W'(WORD_B);
  assign cnt       = popcnt(bus.reglist);
  assign span      = stride * ADDR_W'(cnt);
  assign wbval_new = bus.up ? bus.base + span : bus.base - span;
  // Clearing the lowest set bit retires the register currently presented.
  assign mask_rest = mask_q & (mask_q - NREGS'(1));

  // Every mode walks upward, so only the lowest address of the block matters.
  always_comb begin
    case ({bus.up, bus.pre})
      2'b10:   start_addr = bus.base;
      2'b11:   start_addr = bus.base + stride;
      2'b00:   start_addr = bus.base - span + stride;
      default: start_addr = bus.base - span;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    wb_d        = wb_q;
    wbval_d     = wbval_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    uop_valid_d = uop_valid_q;
    uop_reg_d   = uop_reg_q;
    uop_addr_d  = uop_addr_q;
    uop_load_d  = uop_load_q;
    uop_wb_d    = uop_wb_q;
    uop_last_d  = uop_last_q;
    to_idle     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          wb_d    = bus.wb;
          wbval_d = wbval_new;
          mask_d  = bus.reglist;
          if (bus.reglist != '0) begin
            state_d     = S_XFER;
            busy_d      = 1'b1;
            uop_valid_d = 1'b1;
            uop_reg_d   = lowest(bus.reglist);
            uop_addr_d  = start_addr;
            uop_load_d  = bus.load;
            uop_wb_d    = 1'b0;
            uop_last_d  = (cnt == CNT_W'(1)) && !bus.wb;
          end else if (bus.wb) begin
            state_d     = S_WBACK;
            busy_d      = 1'b1;
            uop_valid_d = 1'b1;
            uop_reg_d   = '0;
            uop_addr_d  = wbval_new;
            uop_load_d  = 1'b0;
            uop_wb_d    = 1'b1;
            uop_last_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_XFER: begin
        if (bus.flush) begin
          to_idle = 1'b1;
        end else if (bus.uop_ready) begin
          if (mask_rest == '0) begin
            if (wb_q) begin
              state_d    = S_WBACK;
              mask_d     = '0;
              uop_reg_d  = '0;
              uop_addr_d = wbval_q;
              uop_load_d = 1'b0;
              uop_wb_d   = 1'b1;
              uop_last_d = 1'b1;
            end else begin
              to_idle = 1'b1;
              done_d  = 1'b1;
            end
          end else begin
            mask_d     = mask_rest;
            uop_reg_d  = lowest(mask_rest);
            uop_addr_d = uop_addr_q + stride;
            uop_last_d = ((mask_rest & (mask_rest - NREGS'(1))) == '0) && !wb_q;
          end
        end
      end
      S_WBACK: begin
        if (bus.flush) begin
          to_idle = 1'b1;
        end else if (bus.uop_ready) begin
          to_idle = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: to_idle = 1'b1;
    endcase

    if (to_idle) begin
      state_d     = S_IDLE;
      mask_d      = '0;
      busy_d      = 1'b0;
      uop_valid_d = 1'b0;
      uop_reg_d   = '0;
      uop_addr_d  = '0;
      uop_load_d  = 1'b0;
      uop_wb_d    = 1'b0;
      uop_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      wb_q        <= 1'b0;
      wbval_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      uop_valid_q <= 1'b0;
      uop_reg_q   <= '0;
      uop_addr_q  <= '0;
      uop_load_q  <= 1'b0;
      uop_wb_q    <= 1'b0;
      uop_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      wb_q        <= wb_d;
      wbval_q     <= wbval_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      uop_valid_q <= uop_valid_d;
      uop_reg_q   <= uop_reg_d;
      uop_addr_q  <= uop_addr_d;
      uop_load_q  <= uop_load_d;
      uop_wb_q    <= uop_wb_d;
      uop_last_q  <= uop_last_d;
    end
  end

  // Combinational so fetch already holds in the capture cycle.
  assign bus.stallF    = busy_q | (bus.start & ~bus.flush);
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.uop_valid = uop_valid_q;
  assign bus.uop_reg   = uop_reg_q;
  assign bus.uop_addr  = uop_addr_q;
  assign bus.uop_load  = uop_load_q;
  assign bus.uop_wb    = uop_wb_q;
  assign bus.uop_last  = uop_last_q;
endmodule

// File: tb/tb_ldm_sequencer.sv
// tb_ldm_sequencer: scoreboard bench for ldm_sequencer. The driver issues
// directed and random block transfers and pushes the expected micro-op list
// (derived from the addressing-mode rules) into a queue; a monitor pops and
// compares on every accepted micro-op and accounts for done pulses.
module tb_ldm_sequencer;
  typedef struct packed {
    logic [3:0]  r;
    logic [31:0] a;
    logic        ld;
    logic        wb;
    logic        last;
  } uop_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_done = 0;
  uop_t exp_q[$];

  ldm_sequencer_if #(.NREGS(16), .ADDR_W(32)) bus ();

  ldm_sequencer #(.NREGS(16), .ADDR_W(32), .WORD_B(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected micro-ops straight from the addressing rules: the block occupies
  // 4*n bytes, its lowest address depends on the mode, registers ascend.
  task automatic push_model(input logic [15:0] rl, input logic [31:0] b,
                            input bit u, input bit p, input bit w, input bit l);
    int          n;
    int          k;
    logic [31:0] span;
    logic [31:0] a;
    uop_t        e;
    n    = $countones(rl);
    span = 32'(4 * n);
    a    = u ? (b + (p ? 32'd4 : 32'd0)) : (b - span + (p ? 32'd0 : 32'd4));
    k    = 0;
    for (int i = 0; i < 16; i++) begin
      if (rl[i]) begin
        e.r    = 4'(i);
        e.a    = a;
        e.ld   = l;
        e.wb   = 1'b0;
        e.last = (k == n - 1) && !w;
        exp_q.push_back(e);
        a = a + 32'd4;
        k++;
      end
    end
    if (w) begin
      e.r    = 4'd0;
      e.a    = u ? b + span : b - span;
      e.ld   = 1'b0;
      e.wb   = 1'b1;
      e.last = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compare each accepted micro-op, verify held outputs, count done.
  logic [39:0] snap;
  bit          hold_pend = 0;
  always @(negedge clk) begin
    uop_t e;
    if (rst) begin
      if (hold_pend)
        chk("hold_stable", 64'({bus.uop_reg, bus.uop_addr, bus.uop_load, bus.uop_wb,
                                bus.uop_last, bus.uop_valid}), 64'(snap));
      hold_pend = 0;
      if (bus.uop_valid && !bus.flush) begin
        if (bus.uop_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_uop", 64'(bus.uop_addr), 64'hDEAD_0000_0000);
          end else begin
            e = exp_q.pop_front();
            chk("uop_reg",  64'(bus.uop_reg),  64'(e.r));
            chk("uop_addr", 64'(bus.uop_addr), 64'(e.a));
            chk("uop_load", 64'(bus.uop_load), 64'(e.ld));
            chk("uop_wb",   64'(bus.uop_wb),   64'(e.wb));
            chk("uop_last", 64'(bus.uop_last), 64'(e.last));
          end
        end else begin
          hold_pend = 1;
          snap = {bus.uop_reg, bus.uop_addr, bus.uop_load, bus.uop_wb, bus.uop_last,
                  bus.uop_valid};
        end
      end
      if (bus.done) begin
        chk("done_expected", 64'(exp_done > 0), 64'd1);
        chk("busy_with_done", 64'(bus.busy), 64'd0);
        if (exp_done > 0) exp_done--;
      end
    end
  end

  // Runs one instruction starting in the current cycle (cycle 0).
  task automatic run_seq(input logic [15:0] rl, input logic [31:0] b,
                         input bit u, input bit p, input bit w, input bit l,
                         input int stall_lo, input int stall_hi, input bit rnd,
                         input int flush_cyc, input int exp_done_cyc);
    bit done_seen;
    done_seen     = 0;
    bus.start     = 1'b1;
    bus.reglist   = rl;
    bus.base      = b;
    bus.up        = u;
    bus.pre       = p;
    bus.wb        = w;
    bus.load      = l;
    bus.flush     = (flush_cyc == 0);
    bus.uop_ready = 1'b1;
    #1;
    chk("stallF_capture", 64'(bus.stallF), 64'(flush_cyc != 0));
    if (flush_cyc != 0) begin
      push_model(rl, b, u, p, w, l);
      exp_done++;
    end
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (flush_cyc >= 0 && cyc == flush_cyc + 1) begin
        bus.flush = 1'b0;
        chk("flush_busy",  64'(bus.busy),      64'd0);
        chk("flush_valid", 64'(bus.uop_valid), 64'd0);
        chk("flush_done",  64'(bus.done),      64'd0);
        done_seen = 1;
        break;
      end
      if (bus.done) begin
        if (exp_done_cyc >= 0) chk("done_cycle", 64'(cyc), 64'(exp_done_cyc));
        done_seen = 1;
        break;
      end
      if (cyc >= stall_lo && cyc <= stall_hi) bus.uop_ready = 1'b0;
      else if (rnd) bus.uop_ready = ($urandom_range(0, 3) != 0);
      else bus.uop_ready = 1'b1;
      if (cyc == flush_cyc) begin
        bus.flush = 1'b1;
        exp_q.delete();
        exp_done--;
      end
      if (rnd && bus.busy && $urandom_range(0, 7) == 0) begin
        bus.start   = 1'b1;
        bus.reglist = 16'($urandom);
        bus.base    = $urandom;
      end
    end
    if (!done_seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.reglist   = '0;
    bus.base      = '0;
    bus.up        = 1'b0;
    bus.pre       = 1'b0;
    bus.wb        = 1'b0;
    bus.load      = 1'b0;
    bus.flush     = 1'b0;
    bus.uop_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_stallF",    64'(bus.stallF),    64'd0);
    chk("rst_uop_valid", 64'(bus.uop_valid), 64'd0);
    chk("rst_uop_reg",   64'(bus.uop_reg),   64'd0);
    chk("rst_uop_addr",  64'(bus.uop_addr),  64'd0);
    chk("rst_uop_load",  64'(bus.uop_load),  64'd0);
    chk("rst_uop_wb",    64'(bus.uop_wb),    64'd0);
    chk("rst_uop_last",  64'(bus.uop_last),  64'd0);
    chk("rst_done",      64'(bus.done),      64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // LDMIA r0!,{r1,r3,r7}
    run_seq(16'h008A, 32'h100, 1, 0, 1, 1, 0, -1, 0, -1, 5);
    // STMDB sp!,{r2,r4}
    run_seq(16'h0014, 32'h200, 0, 1, 1, 0, 0, -1, 0, -1, 4);
    // LDMIB all registers, no writeback
    run_seq(16'hFFFF, 32'h1000, 1, 1, 0, 1, 0, -1, 0, -1, 17);
    // scenario 1 with execute stalled in cycles 2-3
    run_seq(16'h008A, 32'h100, 1, 0, 1, 1, 2, 3, 0, -1, 7);
    // scenario 1 flushed in cycle 2
    run_seq(16'h008A, 32'h100, 1, 0, 1, 1, 0, -1, 0, 2, -1);
    // start together with flush in IDLE
    run_seq(16'h00FF, 32'h300, 1, 0, 1, 1, 0, -1, 0, 0, -1);
    // empty list with writeback
    run_seq(16'h0000, 32'h40, 1, 0, 1, 1, 0, -1, 0, -1, 2);
    // empty list without writeback
    run_seq(16'h0000, 32'h40, 1, 0, 0, 1, 0, -1, 0, -1, 1);
    // DB from base 0 wraps
    run_seq(16'h0003, 32'h0, 0, 1, 0, 1, 0, -1, 0, -1, 3);
    // DA with writeback
    run_seq(16'h8101, 32'h500, 0, 0, 1, 0, 0, -1, 0, -1, 5);

    for (int t = 0; t < 80; t++) begin
      logic [15:0] rl;
      int          fc;
      rl = 16'($urandom);
      if ($urandom_range(0, 2) == 0) rl = rl & 16'($urandom);
      if ($urandom_range(0, 9) == 0) rl = '0;
      fc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 6)) : -1;
      run_seq(rl, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              0, -1, 1, fc, -1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("done_count",  64'(exp_done),     64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ldm_sequencer.md
# ldm_sequencer

Parametrised block-transfer micro-op sequencer for the combined ARM/RISC-V decode stage. It replaces the fixed two-bit LDM/STM micro-counter with a register-list walker. On an accepted block-transfer instruction it emits one memory micro-op per set bit of the register list, then an optional base-writeback micro-op. It holds fetch/decode stalled until the sequence completes or is flushed.

## Interface
Parameters:
- `NREGS`, 16: register-list width; registers numbered 0..NREGS-1.
- `ADDR_W`, 32: address/base width.
- `WORD_B`, 4: byte stride per transferred register.
- Derived: `RIDX_W = $clog2(NREGS)`, `CNT_W = $clog2(NREGS+1)`.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: block-transfer instruction valid in decode.
- `reglist`, in, NREGS: register list, bit i selects register i.
- `base`, in, ADDR_W: base register value (already forwarded).
- `up`, in, 1: U bit. 1 = increment, 0 = decrement.
- `pre`, in, 1: P bit. 1 = before, 0 = after.
- `wb`, in, 1: W bit, write back final base.
- `load`, in, 1: L bit. 1 = LDM, 0 = STM.
- `flush`, in, 1: pipeline flush (FlushE); aborts any sequence.
- `uop_ready`, in, 1: execute stage accepts the current micro-op.
- `busy`, out, 1: sequence in progress.
- `stallF`, out, 1: hold fetch/decode.
- `uop_valid`, out, 1: micro-op presented.
- `uop_reg`, out, RIDX_W: register index for memory micro-op.
- `uop_addr`, out, ADDR_W: memory address; on writeback micro-op, the new base value.
- `uop_load`, out, 1: memory micro-op is a load.
- `uop_wb`, out, 1: micro-op is the base writeback (no memory access).
- `uop_last`, out, 1: final micro-op of the sequence.
- `done`, out, 1: one-cycle pulse when the sequence retires normally.

## Operation
- States: IDLE, XFER, WBACK.
- IDLE:
  - `start & ~flush` captures `reglist`, `load`, `wb`, and the start address; `cnt = popcount(reglist)`.
  - Non-empty list → XFER.
  - Empty list with `wb` → WBACK.
  - Empty list without `wb` → stays IDLE and pulses `done` next cycle.
- Start address:
  - IA (`up=1,pre=0`): base.
  - IB (`up=1,pre=1`): base+WORD_B.
  - DA (`up=0,pre=0`): base−WORD_B·cnt+WORD_B.
  - DB (`up=0,pre=1`): base−WORD_B·cnt.
- Transfer order and addressing:
  - Transfers always run lowest-numbered register first, at ascending addresses.
  - `uop_reg` is the lowest set bit of the remaining mask (priority encoder).
  - On each accepted micro-op, that bit is cleared and the address advances by +WORD_B.
- Writeback value: base + WORD_B·cnt if `up`, else base − WORD_B·cnt. Computed at capture, ADDR_W modulo arithmetic (wraps silently).
- XFER:
  - Leaving condition: accepted micro-op with remaining mask one-hot.
  - Goes to WBACK if `wb`, else to IDLE with `done` pulsed.
- WBACK: presents one micro-op with `uop_wb=1`, `uop_addr`=writeback value, `uop_last=1`. On acceptance → IDLE, `done` pulsed.
- `uop_last`:
  - High on the final memory micro-op when `~wb`.
  - High on the WBACK micro-op.
- `flush`:
  - In any state, forces IDLE on the next edge and clears the mask.
  - No `done` pulse.
  - The current micro-op is dropped even if `uop_ready` is high.
  - `flush` together with `start` in IDLE: flush wins, start is ignored.
- `start` is ignored while `busy`.

## Timing
- Reset values: state IDLE, mask 0, and `busy`, `stallF`, `uop_valid`, `uop_reg`, `uop_addr`, `uop_load`, `uop_wb`, `uop_last`, `done` all 0.
- All `uop_*`, `busy`, and `done` are registered.
- `stallF = busy | (start & ~flush)`, combinational, so fetch holds in the capture cycle.
- Start accepted at edge 0; first `uop_valid` visible in cycle 1.
- Throughput is one micro-op per cycle while `uop_ready=1`.
- Sequence of N registers plus writeback, with no stalls: micro-ops in cycles 1..N+1, `done` in cycle N+2, `busy` low from cycle N+2.
- While `uop_valid & ~uop_ready`, all `uop_*` outputs hold stable.
- `busy` drops in the same cycle `done` is high.
- A new `start` may be accepted in that cycle.

## Test plan
- LDMIA r0!,{r1,r3,r7}, base=0x100 → (r1,0x100),(r3,0x104),(r7,0x108) with `uop_load=1`, then wb 0x10C with `uop_last=1`; `done` at cycle 5.
- STMDB sp!,{r2,r4}, base=0x200 → (r2,0x1F8),(r4,0x1FC) with `uop_load=0`, then wb 0x1F8.
- LDMIB, reglist=0xFFFF, base=0x1000, no wb → 16 micro-ops at 0x1004..0x1040; `uop_last` on r15; no WBACK.
- Same as scenario 1 with `uop_ready` low in cycles 2–3 → (r3,0x104) held for 3 cycles; order and values unchanged; `done` at cycle 7.
- Flush asserted in cycle 2 of scenario 1 → no micro-op after cycle 2; IDLE in cycle 3; no `done`. `start`+`flush` together in IDLE → nothing is captured.
- Empty list with wb, base=0x40 → a single wb micro-op carrying 0x40. Empty list without wb → no micro-ops; `done` in cycle 1. Base=0x0 with DB and 2 registers → addresses 0xFFFFFFF8/0xFFFFFFFC (wrap).
